axi_lite_slave_regs: RTL and testbench

AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

---
 rtl/axi_lite_slave_regs.sv | 154 +++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// axi_lite_slave_regs : AXI4-Lite slave with NREG-1 R/W words + one status word
// Revision 1.0 - initial release
// ============================================================================
module axi_lite_slave_regs #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NREG = 8
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               AWVALID,
  input  logic [AW-1:0]      AWADDR,
  output logic               AWREADY,
  input  logic               WVALID,
  input  logic [DW-1:0]      WDATA,
  output logic               WREADY,
  output logic               BVALID,
  output logic [1:0]         BRESP,
  input  logic               BREADY,
  input  logic               ARVALID,
  input  logic [AW-1:0]      ARADDR,
  output logic               ARREADY,
  output logic               RVALID,
  output logic [DW-1:0]      RDATA,
  output logic [1:0]         RRESP,
  input  logic               RREADY,
  output logic [NREG*DW-1:0] REG_OUT,
  input  logic [DW-1:0]      STATUS_IN
);

  localparam int              c_iw     = $clog2(NREG);
  localparam logic [c_iw-1:0] c_last   = c_iw'(NREG - 1);
  localparam logic [1:0]      c_okay   = 2'b00;
  localparam logic [1:0]      c_slverr = 2'b10;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> (2 + c_iw)) == '0;
  endfunction

  function automatic logic [c_iw-1:0] reg_index(input logic [AW-1:0] a);
    return a[2 +: c_iw];
  endfunction

  logic [DW-1:0]   r_regs [NREG-1];
  logic            r_aw_held;
  logic            r_w_held;
  logic [AW-1:0]   r_aw_addr;
  logic [DW-1:0]   r_w_data;

  logic            w_aw_hs;
  logic            w_w_hs;
  logic            w_commit;
  logic            w_wr_ok;
  logic [c_iw-1:0] w_wr_idx;
  logic            w_aw_held_nxt;
  logic            w_w_held_nxt;
  logic            w_bvalid_nxt;

  assign w_aw_hs  = AWVALID && AWREADY;
  assign w_w_hs   = WVALID && WREADY;
  // Commit happens the edge after both halves are held, so readies are already low.
  assign w_commit = r_aw_held && r_w_held;
  assign w_wr_idx = reg_index(r_aw_addr);
  assign w_wr_ok  = in_range(r_aw_addr) && (w_wr_idx != c_last);

  assign w_aw_held_nxt = (r_aw_held || w_aw_hs) && !w_commit;
  assign w_w_held_nxt  = (r_w_held || w_w_hs) && !w_commit;
  assign w_bvalid_nxt  = w_commit || (BVALID && !BREADY);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_addr <= '0;
      r_w_data  <= '0;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= c_okay;
    end else begin
      r_aw_held <= w_aw_held_nxt;
      r_w_held  <= w_w_held_nxt;
      if (w_aw_hs) r_aw_addr <= AWADDR;
      if (w_w_hs)  r_w_data  <= WDATA;
      BVALID    <= w_bvalid_nxt;
      if (w_commit) BRESP <= w_wr_ok ? c_okay : c_slverr;
      AWREADY   <= !w_aw_held_nxt && !w_bvalid_nxt;
      WREADY    <= !w_w_held_nxt && !w_bvalid_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < NREG - 1; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int i = 0; i < NREG - 1; i++) begin
        if (w_wr_idx == c_iw'(i)) r_regs[i] <= r_w_data;
      end
    end
  end

  logic            w_ar_hs;
  logic            w_rvalid_nxt;
  logic [c_iw-1:0] w_rd_idx;
  logic [DW-1:0]   w_rd_data;
  logic [1:0]      w_rd_resp;

  assign w_ar_hs      = ARVALID && ARREADY;
  assign w_rvalid_nxt = w_ar_hs || (RVALID && !RREADY);
  assign w_rd_idx     = reg_index(ARADDR);

  // Reads see register contents before any write committing on the same edge.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_slverr;
    if (in_range(ARADDR)) begin
      w_rd_resp = c_okay;
      if (w_rd_idx == c_last) begin
        w_rd_data = STATUS_IN;
      end else begin
        for (int i = 0; i < NREG - 1; i++) begin
          if (w_rd_idx == c_iw'(i)) w_rd_data = r_regs[i];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= c_okay;
    end else begin
      RVALID  <= w_rvalid_nxt;
      ARREADY <= !w_rvalid_nxt;
      if (w_ar_hs) begin
        RDATA <= w_rd_data;
        RRESP <= w_rd_resp;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NREG - 1; gi++) begin : g_reg_out
      assign REG_OUT[gi*DW +: DW] = r_regs[gi];
    end
  endgenerate
  assign REG_OUT[NREG*DW-1 -: DW] = '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave_regs.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_slave_regs : directed + randomized checks against a word-array model
// Revision 1.0 - initial release
// ============================================================================
module tb_axi_lite_slave_regs;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NREG = 8;

  logic               CLK;
  logic               RESETn;
  logic               AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [AW-1:0]      AWADDR, ARADDR;
  logic [DW-1:0]      WDATA, STATUS_IN;
  logic               AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]         BRESP, RRESP;
  logic [DW-1:0]      RDATA;
  logic [NREG*DW-1:0] REG_OUT;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [NREG-1];

  axi_lite_slave_regs #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .REG_OUT(REG_OUT), .STATUS_IN(STATUS_IN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Model: word address = addr/4; anything at or beyond NREG words is out of range.
  function automatic bit m_in_range(input logic [31:0] a);
    return (a / 4) < NREG;
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a / 4) % NREG);
  endfunction

  function automatic logic [NREG*DW-1:0] m_regout();
    logic [NREG*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NREG - 1; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic logic [31:0] gen_addr();
    int sel;
    sel = $urandom_range(0, 4);
    if (sel < 4) return 32'($urandom_range(0, NREG*4 - 1));
    return $urandom | 32'h0000_0100;
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output bit ok);
    bit aw_done, w_done, aw_go, w_go;
    aw_done = 0; w_done = 0; ok = 0; resp = 2'b11;
    @(negedge CLK);
    for (int c = 0; c < 100 && !(aw_done && w_done); c++) begin
      if (c == aw_dly) begin AWVALID = 1'b1; AWADDR = addr; end
      if (c == w_dly)  begin WVALID = 1'b1; WDATA = data; end
      aw_go = AWVALID && AWREADY;
      w_go  = WVALID && WREADY;
      tick();
      if (aw_go) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_go)  begin WVALID = 1'b0; w_done = 1; end
    end
    if (!(aw_done && w_done)) return;
    for (int c = 0; c < 100 && !BVALID; c++) tick();
    if (!BVALID) return;
    resp = BRESP;
    repeat (b_dly) tick();
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    ok = 1;
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [31:0] status, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp, output bit ok);
    ok = 0; data = 'x; resp = 2'b11;
    @(negedge CLK);
    ARVALID = 1'b1; ARADDR = addr; STATUS_IN = status;
    for (int c = 0; c < 100 && !ARREADY; c++) tick();
    if (!ARREADY) begin ARVALID = 1'b0; return; end
    tick();
    ARVALID = 1'b0;
    if (!RVALID) return;
    data = RDATA;
    resp = RRESP;
    repeat (r_dly) tick();
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    ok = 1;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b expected 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP, RDATA} !== '0 || REG_OUT !== '0) begin
      errors++;
      $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h reg_out=%h expected all 0", BRESP, RRESP, RDATA, REG_OUT);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < NREG - 1; i++) model[i] = '0;
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] d; logic [1:0] r; bit ok;
    @(negedge CLK);
    AWVALID = 1'b1; AWADDR = 32'h04; WVALID = 1'b1; WDATA = 32'hDEADBEEF; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b000) begin
      errors++;
      $display("FAIL same_cycle_after_hs: bvalid/awready/wready=%b expected 000", {BVALID, AWREADY, WREADY});
    end
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || REG_OUT[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL same_cycle_commit: bvalid=%b bresp=%b reg1=%h expected 1 00 deadbeef", BVALID, BRESP, REG_OUT[63:32]);
    end
    model[1] = 32'hDEADBEEF;
    tick();
    BREADY = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL same_cycle_bresp_done: bvalid/awready/wready=%b expected 011", {BVALID, AWREADY, WREADY});
    end
    read_txn(32'h04, 32'h0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_readback: ok=%0d data=%h resp=%b expected deadbeef 00", ok, d, r);
    end
  endtask

  task automatic test_w_before_aw();
    @(negedge CLK);
    WVALID = 1'b1; WDATA = 32'h1234;
    tick();
    WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (BVALID !== 1'b0 || REG_OUT[95:64] !== model[2] || WREADY !== 1'b0 || AWREADY !== 1'b1) begin
        errors++;
        $display("FAIL w_first_wait: bvalid=%b reg2=%h wready=%b awready=%b expected 0 %h 0 1",
                 BVALID, REG_OUT[95:64], WREADY, AWREADY, model[2]);
      end
      if (c < 2) tick();
    end
    AWVALID = 1'b1; AWADDR = 32'h08;
    tick();
    AWVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || REG_OUT[95:64] !== 32'h1234) begin
      errors++;
      $display("FAIL w_first_commit: bvalid=%b bresp=%b reg2=%h expected 1 00 00001234", BVALID, BRESP, REG_OUT[95:64]);
    end
    model[2] = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
        errors++;
        $display("FAIL bresp_stall: bvalid=%b bresp=%b awready=%b wready=%b expected 1 00 0 0", BVALID, BRESP, AWREADY, WREADY);
      end
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      errors++;
      $display("FAIL bresp_release: bvalid/awready/wready=%b expected 011", {BVALID, AWREADY, WREADY});
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r; bit ok;
    write_txn(32'h1C, $urandom, 0, 0, 0, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || REG_OUT !== m_regout()) begin
      errors++;
      $display("FAIL err_write_status: ok=%0d bresp=%b reg_out=%h expected 10 %h", ok, r, REG_OUT, m_regout());
    end
    write_txn(32'h40, $urandom, 1, 0, 0, r, ok);
    checks++;
    if (!ok || r !== 2'b10 || REG_OUT !== m_regout()) begin
      errors++;
      $display("FAIL err_write_oor: ok=%0d bresp=%b reg_out=%h expected 10 %h", ok, r, REG_OUT, m_regout());
    end
    read_txn(32'h1C, 32'hA5A5A5A5, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'hA5A5A5A5 || r !== 2'b00) begin
      errors++;
      $display("FAIL err_read_status: ok=%0d data=%h resp=%b expected a5a5a5a5 00", ok, d, r);
    end
    read_txn(32'h40, 32'h0, 1, d, r, ok);
    checks++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      errors++;
      $display("FAIL err_read_oor: ok=%0d data=%h resp=%b expected 00000000 10", ok, d, r);
    end
  endtask

  task automatic test_read_write_collision();
    logic [31:0] d; logic [1:0] r; bit ok;
    write_txn(32'h00, 32'h11, 0, 0, 0, r, ok);
    model[0] = 32'h11;
    @(negedge CLK);
    AWVALID = 1'b1; AWADDR = 32'h00; WVALID = 1'b1; WDATA = 32'h55; BREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 32'h00;
    tick();
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h11) begin
      errors++;
      $display("FAIL collision_old_value: rvalid=%b rdata=%h expected 1 00000011", RVALID, RDATA);
    end
    checks++;
    if (BVALID !== 1'b1 || REG_OUT[31:0] !== 32'h55) begin
      errors++;
      $display("FAIL collision_commit: bvalid=%b reg0=%h expected 1 00000055", BVALID, REG_OUT[31:0]);
    end
    model[0] = 32'h55;
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    read_txn(32'h00, 32'h0, 0, d, r, ok);
    checks++;
    if (!ok || d !== 32'h55 || r !== 2'b00) begin
      errors++;
      $display("FAIL collision_new_value: ok=%0d data=%h resp=%b expected 00000055 00", ok, d, r);
    end
  endtask

  task automatic test_read_stall();
    int k, j;
    logic [31:0] exp_d, wd;
    logic [1:0] wr; bit wok;
    k = $urandom_range(0, NREG - 2);
    j = (k + 1) % (NREG - 1);
    exp_d = model[k];
    wd = $urandom;
    @(negedge CLK);
    ARVALID = 1'b1; ARADDR = 32'(k * 4); RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    fork
      write_txn(32'(j * 4), wd, 0, 0, 0, wr, wok);
      for (int c = 0; c < 5; c++) begin
        checks++;
        if (RVALID !== 1'b1 || RDATA !== exp_d || RRESP !== 2'b00 || ARREADY !== 1'b0) begin
          errors++;
          $display("FAIL rresp_stall: rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h 00 0",
                   RVALID, RDATA, RRESP, ARREADY, exp_d);
        end
        tick();
      end
    join
    model[j] = wd;
    checks++;
    if (!wok || wr !== 2'b00 || REG_OUT !== m_regout() || RVALID !== 1'b1) begin
      errors++;
      $display("FAIL stall_concurrent_write: ok=%0d bresp=%b reg_out=%h rvalid=%b expected 00 %h 1",
               wok, wr, REG_OUT, RVALID, m_regout());
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checks++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      errors++;
      $display("FAIL rresp_release: rvalid/arready=%b expected 01", {RVALID, ARREADY});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    AWVALID = 1'b1; AWADDR = 32'h0C;
    tick();
    AWVALID = 1'b0;
    #2 RESETn = 1'b0;
    #1;
    for (int i = 0; i < NREG - 1; i++) model[i] = '0;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0 || {BRESP, RRESP, RDATA} !== '0 || REG_OUT !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: hs=%b bresp=%b rresp=%b rdata=%h reg_out=%h expected all 0",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID}, BRESP, RRESP, RDATA, REG_OUT);
    end
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL mid_reset_release: got %b expected 111", {AWREADY, WREADY, ARREADY});
    end
    @(negedge CLK);
    WVALID = 1'b1; WDATA = 32'h777; BREADY = 1'b1;
    tick();
    WVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b0 || REG_OUT !== '0) begin
      errors++;
      $display("FAIL mid_reset_aw_discarded: bvalid=%b reg_out=%h expected 0 0", BVALID, REG_OUT);
    end
    AWVALID = 1'b1; AWADDR = 32'h0C;
    tick();
    AWVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b1 || REG_OUT[127:96] !== 32'h777) begin
      errors++;
      $display("FAIL mid_reset_recover: bvalid=%b reg3=%h expected 1 00000777", BVALID, REG_OUT[127:96]);
    end
    model[3] = 32'h777;
    tick();
    BREADY = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] a, d, st, exp_d;
    logic [1:0] r, exp_r;
    bit ok;
    int idx;
    for (int n = 0; n < 40; n++) begin
      a = gen_addr();
      idx = m_index(a);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        write_txn(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), r, ok);
        if (m_in_range(a) && idx < NREG - 1) begin
          model[idx] = d;
          exp_r = 2'b00;
        end else begin
          exp_r = 2'b10;
        end
        checks++;
        if (!ok || r !== exp_r || REG_OUT !== m_regout()) begin
          errors++;
          $display("FAIL rand_write addr=%h: ok=%0d bresp=%b reg_out=%h expected %b %h", a, ok, r, REG_OUT, exp_r, m_regout());
        end
      end else begin
        st = $urandom;
        read_txn(a, st, $urandom_range(0, 2), d, r, ok);
        if (!m_in_range(a)) begin
          exp_d = 32'h0; exp_r = 2'b10;
        end else if (idx == NREG - 1) begin
          exp_d = st; exp_r = 2'b00;
        end else begin
          exp_d = model[idx]; exp_r = 2'b00;
        end
        checks++;
        if (!ok || d !== exp_d || r !== exp_r) begin
          errors++;
          $display("FAIL rand_read addr=%h: ok=%0d data=%h resp=%b expected %h %b", a, ok, d, r, exp_d, exp_r);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bcnt, rcnt;
    logic [31:0] d;
    d = $urandom;
    bcnt = 0; rcnt = 0;
    @(negedge CLK);
    AWVALID = 1'b1; AWADDR = 32'h14; WVALID = 1'b1; WDATA = d; BREADY = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h14; RREADY = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (BVALID) bcnt++;
      if (RVALID) rcnt++;
    end
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    repeat (4) tick();
    BREADY = 1'b0; RREADY = 1'b0;
    model[5] = d;
    checks++;
    if (bcnt != 10) begin
      errors++;
      $display("FAIL b2b_write_rate: got %0d responses in 30 cycles expected 10", bcnt);
    end
    checks++;
    if (rcnt != 15) begin
      errors++;
      $display("FAIL b2b_read_rate: got %0d responses in 30 cycles expected 15", rcnt);
    end
    checks++;
    if (REG_OUT !== m_regout() || {AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_final: reg_out=%h ready=%b expected %h 111", REG_OUT, {AWREADY, WREADY, ARREADY}, m_regout());
    end
  endtask

  initial begin
    RESETn = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; ARADDR = '0; WDATA = '0; STATUS_IN = '0;
    test_reset();
    test_same_cycle_write();
    test_w_before_aw();
    test_errors();
    test_read_write_collision();
    test_read_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
